// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Glyphs are active-high, bit order gfedcba ([6]=g ... [0]=a); DP_BIT is
// the decimal-point position within the 8-bit segment bus.
package seg_scan_driver_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_driver_seg_decoder.sv
// Combinational nibble -> active-high 7-segment glyph.
// Ports:
//   nibble   in  4  digit value
//   hex_en   in  1  1 = show A-F, 0 = values 10..15 decode blank
//   glyph_c  out 7  gfedcba, active-high
module seg_scan_driver_seg_decoder
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_en,
  output logic [SEG_W-1:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_BLANK;
    unique case (nibble)
      4'h0: glyph_c = SEG_0;
      4'h1: glyph_c = SEG_1;
      4'h2: glyph_c = SEG_2;
      4'h3: glyph_c = SEG_3;
      4'h4: glyph_c = SEG_4;
      4'h5: glyph_c = SEG_5;
      4'h6: glyph_c = SEG_6;
      4'h7: glyph_c = SEG_7;
      4'h8: glyph_c = SEG_8;
      4'h9: glyph_c = SEG_9;
      4'hA: glyph_c = hex_en ? SEG_A : SEG_BLANK;
      4'hB: glyph_c = hex_en ? SEG_B : SEG_BLANK;
      4'hC: glyph_c = hex_en ? SEG_C : SEG_BLANK;
      4'hD: glyph_c = hex_en ? SEG_D : SEG_BLANK;
      4'hE: glyph_c = hex_en ? SEG_E : SEG_BLANK;
      4'hF: glyph_c = hex_en ? SEG_F : SEG_BLANK;
      default: glyph_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment display driver with per-frame snapshot,
// leading-zero blanking, forced blanking, cursor blink and inter-digit guard.
// Ports:
//   clk_osc     in   1           oscillator clock
//   reset       in   1           async, active-high
//   enable      in   1           0 = display dark, scan held
//   num         in   4*N_DIGITS  digit nibbles, [3:0] = digit 0 (rightmost)
//   blank_mask  in   N_DIGITS    1 = force digit dark (seg+dp)
//   blink_sel   in   N_DIGITS    1 = digit blinks
//   dp_mask     in   N_DIGITS    1 = decimal point lit
//   anode       out  N_DIGITS    digit enables (registered)
//   eSeg        out  8           [7]=dp, [6:0]=gfedcba (registered)
//   frame_tick  out  1           1-cycle pulse after each frame wrap
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD        = 0,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned LZ_BLANK     = 1,
  parameter int unsigned HEX_EN       = 0,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                  clk_osc,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] num,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_sel,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            eSeg,
  output logic                  frame_tick
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [PRE_W:0]   GUARD_END = (PRE_W+1)'(GUARD);
  localparam logic             INV       = (ACTIVE_LOW != 0);
  localparam logic             LZ_EN     = (LZ_BLANK != 0);
  localparam logic             HEX_ON    = (HEX_EN != 0);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_q, snap_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [7:0]            seg_lit_q, seg_lit_d;
  logic                  live_q, live_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]            eseg_q, eseg_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_tick;
  logic                  wrap;
  logic [4*N_DIGITS-1:0] disp_src;
  logic [3:0]            cur_nib;
  logic                  cur_blank, cur_blink, cur_dp, lz_zero;
  logic [SEG_W-1:0]      glyph;

  // Prescaler, digit index, frame snapshot and blink counter.
  always_comb begin
    pre_d         = pre_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    slot_tick     = enable && (pre_q == PRE_LAST);
    wrap          = slot_tick && (idx_q == IDX_LAST);
    frame_tick_d  = wrap;

    if (enable) begin
      pre_d = slot_tick ? '0 : pre_q + PRE_W'(1);
    end
    if (slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      snap_d = num;
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Per-digit attribute select for the slot about to be shown. Digit 0 of a
  // new frame reads num directly, since snap only catches up on this edge.
  always_comb begin
    disp_src  = (idx_d == '0) ? num : snap_q;
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_dp    = 1'b0;
    lz_zero   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        cur_nib   = disp_src[4*i +: 4];
        cur_blank = blank_mask[i];
        cur_blink = blink_sel[i];
        cur_dp    = dp_mask[i];
      end
      if ((IDX_W'(i) >= idx_d) && (snap_q[4*i +: 4] != 4'h0)) begin
        lz_zero = 1'b0;
      end
    end
  end

  seg_scan_driver_seg_decoder u_dec (
    .nibble  (cur_nib),
    .hex_en  (HEX_ON),
    .glyph_c (glyph)
  );

  // Output register inputs; polarity applied last.
  always_comb begin
    logic                force_dark;
    logic                lz_dark;
    logic [7:0]          lit_now;
    logic [7:0]          seg_act;
    logic [N_DIGITS-1:0] anode_act;
    logic                guard_done;

    seg_lit_d  = seg_lit_q;
    live_d     = live_q | slot_tick;
    force_dark = cur_blank | (cur_blink & blink_phase_d);
    lz_dark    = LZ_EN && (idx_d != '0) && lz_zero;
    lit_now    = '0;
    lit_now[SEG_W-1:0] = (force_dark | lz_dark) ? SEG_BLANK : glyph;
    lit_now[DP_BIT]    = cur_dp & ~force_dark;

    if (slot_tick) begin
      seg_lit_d = lit_now;
    end
    seg_act = slot_tick ? lit_now : seg_lit_q;

    // Guard: anode stays off for the first GUARD counts of each slot.
    guard_done = ({1'b0, pre_d} + (PRE_W+1)'(1)) > GUARD_END;
    anode_act  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      anode_act[i] = (IDX_W'(i) == idx_d);
    end
    if (!(enable && live_d && guard_done)) begin
      anode_act = '0;
    end

    eseg_d  = (enable ? seg_act : 8'h00) ^ {8{INV}};
    anode_d = anode_act ^ {N_DIGITS{INV}};
  end

  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      pre_q         <= '0;
      idx_q         <= IDX_LAST;
      snap_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_lit_q     <= '0;
      live_q        <= 1'b0;
      anode_q       <= {N_DIGITS{INV}};
      eseg_q        <= {8{INV}};
      frame_tick_q  <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_lit_q     <= seg_lit_d;
      live_q        <= live_d;
      anode_q       <= anode_d;
      eseg_q        <= eseg_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign eSeg       = eseg_q;
  assign frame_tick = frame_tick_q;

endmodule
